// File: rtl/reset_run_sequencer.sv
// Owns a DUT's reset and run window: PRE delay, DUT reset pulse, timed RUN window, then sticky DONE.
// Define RRS_SIGNATURE_EN to add a 16-bit MISR over the LED bus during RUN (oSignature port).
module reset_run_sequencer #(
  parameter int LED_WIDTH  = 8,
  parameter int PRE_CYCLES = 10,
  parameter int RST_CYCLES = 5,
  parameter int RUN_CYCLES = 100,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [LED_WIDTH-1:0] iLed,
  input  logic                 iRestart,
  output logic                 oDutReset,
  output logic                 oRunning,
  output logic                 oDone,
  output logic [CNT_WIDTH-1:0] oChangeCount,
  output logic [LED_WIDTH-1:0] oLastLed
`ifdef RRS_SIGNATURE_EN
  ,
  output logic [15:0]          oSignature
`endif
);

  typedef enum logic [1:0] {
    ST_PRE,
    ST_RST,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PRE_LAST = CNT_WIDTH'(PRE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RUN_LAST = CNT_WIDTH'(RUN_CYCLES - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [CNT_WIDTH-1:0] r_phaseCnt;
  logic [CNT_WIDTH-1:0] w_nextPhaseCnt;
  logic                 w_restart;
  logic                 r_dutReset;
  logic                 r_running;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] r_changeCount;
  logic [LED_WIDTH-1:0] r_lastLed;

  always_comb begin
    w_nextState     = r_state;
    w_nextPhaseCnt  = r_phaseCnt + CNT_WIDTH'(1);
    w_restart       = 1'b0;
    case (r_state)
      ST_PRE: begin
        if (r_phaseCnt == PRE_LAST) begin
          w_nextState    = ST_RST;
          w_nextPhaseCnt = '0;
        end
      end
      ST_RST: begin
        if (r_phaseCnt == RST_LAST) begin
          w_nextState    = ST_RUN;
          w_nextPhaseCnt = '0;
        end
      end
      ST_RUN: begin
        if (r_phaseCnt == RUN_LAST) begin
          w_nextState    = ST_DONE;
          w_nextPhaseCnt = '0;
        end
      end
      ST_DONE: begin
        w_nextPhaseCnt = r_phaseCnt;
        if (iRestart) begin
          w_nextState    = ST_PRE;
          w_nextPhaseCnt = '0;
          w_restart      = 1'b1;
        end
      end
      default: begin
        w_nextState    = ST_PRE;
        w_nextPhaseCnt = '0;
      end
    endcase
  end

  // Phase flags are decoded from the next state so each one rises on its state's first cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_PRE;
      r_phaseCnt    <= '0;
      r_dutReset    <= 1'b0;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_lastLed     <= '0;
      r_changeCount <= '0;
    end else begin
      r_state    <= w_nextState;
      r_phaseCnt <= w_nextPhaseCnt;
      r_dutReset <= (w_nextState == ST_RST);
      r_running  <= (w_nextState == ST_RUN);
      r_done     <= (w_nextState == ST_DONE);
      r_lastLed  <= iLed;
      if (w_restart) begin
        r_changeCount <= '0;
      end else if ((r_state == ST_RUN) && (iLed != r_lastLed) && (r_changeCount != '1)) begin
        r_changeCount <= r_changeCount + CNT_WIDTH'(1);
      end
    end
  end

  assign oDutReset    = r_dutReset;
  assign oRunning     = r_running;
  assign oDone        = r_done;
  assign oChangeCount = r_changeCount;
  assign oLastLed     = r_lastLed;

`ifdef RRS_SIGNATURE_EN
  logic [15:0] r_signature;

  // CRC-16-CCITT style shift with the LED sample folded into the low bits.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_signature <= 16'hFFFF;
    end else if (w_restart) begin
      r_signature <= 16'hFFFF;
    end else if (r_state == ST_RUN) begin
      r_signature <= ({r_signature[14:0], 1'b0} ^ (r_signature[15] ? 16'h1021 : 16'h0000))
                     ^ 16'(iLed);
    end
  end

  assign oSignature = r_signature;
`endif

endmodule

// File: tb/tb_reset_run_sequencer.sv
// Scoreboard bench for reset_run_sequencer: an edge-count model of the schedule pushes
// expected outputs per cycle, popped and checked after each rising edge.
module tb_reset_run_sequencer;

  localparam int PRE       = 10;
  localparam int RST       = 5;
  localparam int RUN       = 100;
  localparam int RUN_START = PRE + RST;
  localparam int DONE_E    = PRE + RST + RUN;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  iLed;
  logic        iRestart;
  logic        oDutReset;
  logic        oRunning;
  logic        oDone;
  logic [15:0] oChangeCount;
  logic [7:0]  oLastLed;
  logic [15:0] oSignature;

  logic [7:0]  iLed2;
  logic        oDutReset2;
  logic        oRunning2;
  logic        oDone2;
  logic [3:0]  oChangeCount2;
  logic [7:0]  oLastLed2;
  logic [15:0] oSignature2;

  always #5 Clock = ~Clock;

  reset_run_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iLed        (iLed),
    .iRestart    (iRestart),
    .oDutReset   (oDutReset),
    .oRunning    (oRunning),
    .oDone       (oDone),
    .oChangeCount(oChangeCount),
    .oLastLed    (oLastLed)
`ifdef RRS_SIGNATURE_EN
    ,
    .oSignature  (oSignature)
`endif
  );

  // Narrow counter instance: 16 RUN cycles into a 4-bit counter must saturate at 15.
  reset_run_sequencer #(
    .LED_WIDTH (8),
    .PRE_CYCLES(2),
    .RST_CYCLES(2),
    .RUN_CYCLES(16),
    .CNT_WIDTH (4)
  ) dutSat (
    .Clock       (Clock),
    .Reset       (Reset),
    .iLed        (iLed2),
    .iRestart    (1'b0),
    .oDutReset   (oDutReset2),
    .oRunning    (oRunning2),
    .oDone       (oDone2),
    .oChangeCount(oChangeCount2),
    .oLastLed    (oLastLed2)
`ifdef RRS_SIGNATURE_EN
    ,
    .oSignature  (oSignature2)
`endif
  );

`ifndef RRS_SIGNATURE_EN
  assign oSignature  = 16'hFFFF;
  assign oSignature2 = 16'hFFFF;
`endif

  typedef struct {
    logic        dutReset;
    logic        running;
    logic        done;
    logic [15:0] changeCount;
    logic [7:0]  lastLed;
    logic [15:0] sig;
  } exp_t;

  exp_t        q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          e;
  int          mode;
  bit          aligned;
  logic [15:0] mCnt;
  logic [15:0] mSig;
  logic [7:0]  mPrev;

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] d);
    return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, d};
  endfunction

  // LED value driven before the edge whose pre-edge sequence position is k.
  function automatic logic [7:0] ledFor(input int m, input int k);
    logic [7:0] v;
    v = 8'h00;
    if (m == 1) begin
      if (k >= RUN_START && k < DONE_E) v = (((k - RUN_START) % 2) == 0) ? 8'hFF : 8'h00;
    end else if (m >= 2) begin
      v = 8'(k * 37 + 5);
      if (m == 3 && k == 40) v = v ^ 8'h04;
    end
    return v;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    e     = 0;
    mCnt  = 16'h0000;
    mSig  = 16'hFFFF;
    mPrev = 8'h00;
  endtask

  task automatic checkReset(input string tag);
    checkValue({tag, "_dutReset"}, {31'd0, oDutReset}, 32'd0);
    checkValue({tag, "_running"}, {31'd0, oRunning}, 32'd0);
    checkValue({tag, "_done"}, {31'd0, oDone}, 32'd0);
    checkValue({tag, "_count"}, {16'd0, oChangeCount}, 32'd0);
    checkValue({tag, "_lastLed"}, {24'd0, oLastLed}, 32'd0);
    checkValue({tag, "_signature"}, {16'd0, oSignature}, 32'h0000FFFF);
    checkValue({tag, "_satCount"}, {28'd0, oChangeCount2}, 32'd0);
    checkValue({tag, "_satDone"}, {31'd0, oDone2}, 32'd0);
  endtask

  task automatic checkOutput();
    exp_t x;
    if (q.size() == 0) begin
      checkValue("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      x = q.pop_front();
      checkValue("dutReset", {31'd0, oDutReset}, {31'd0, x.dutReset});
      checkValue("running", {31'd0, oRunning}, {31'd0, x.running});
      checkValue("done", {31'd0, oDone}, {31'd0, x.done});
      checkValue("changeCount", {16'd0, oChangeCount}, {16'd0, x.changeCount});
      checkValue("lastLed", {24'd0, oLastLed}, {24'd0, x.lastLed});
`ifdef RRS_SIGNATURE_EN
      checkValue("signature", {16'd0, oSignature}, {16'd0, x.sig});
`endif
    end
    if (aligned) begin
      if (e == 18) checkValue("sat_count_e18", {28'd0, oChangeCount2}, 32'd14);
      if (e == 20) checkValue("sat_count_e20", {28'd0, oChangeCount2}, 32'd15);
      if (e == 20) checkValue("sat_done_e20", {31'd0, oDone2}, 32'd1);
      if (e == 60) checkValue("sat_count_hold", {28'd0, oChangeCount2}, 32'd15);
    end
  endtask

  // Drive one cycle of stimulus, advance the schedule model and queue the expected outputs.
  task automatic applyStimulus(input logic restart);
    exp_t       x;
    logic [7:0] led;
    int         oldE;
    oldE     = e;
    led      = ledFor(mode, oldE);
    iLed     = led;
    iRestart = restart;
    iLed2    = ~iLed2;
    if (restart && oldE >= DONE_E) begin
      e    = 0;
      mCnt = 16'h0000;
      mSig = 16'hFFFF;
    end else begin
      if (oldE >= RUN_START && oldE < DONE_E) begin
        if (led != mPrev && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        mSig = misr(mSig, led);
      end
      e = oldE + 1;
    end
    mPrev         = led;
    x.dutReset    = (e >= PRE && e < RUN_START);
    x.running     = (e >= RUN_START && e < DONE_E);
    x.done        = (e >= DONE_E);
    x.changeCount = mCnt;
    x.lastLed     = led;
    x.sig         = mSig;
    q.push_back(x);
    @(posedge Clock);
    #1;
    checkOutput();
  endtask

  initial begin
    Reset    = 1'b1;
    iLed     = 8'h00;
    iRestart = 1'b0;
    iLed2    = 8'h00;
    mode     = 0;
    aligned  = 1'b0;
    resetModel();
    repeat (2) @(posedge Clock);
    #1;
    checkReset("reset");
    #2 Reset = 1'b0;
    aligned = 1'b1;

    // Idle LED: baseline 10/5/100 schedule.
    repeat (DONE_E + 1) applyStimulus(1'b0);
    checkValue("idle_count_at_done", {16'd0, oChangeCount}, 32'd0);

    // Restart from DONE, toggling LEDs, with a restart request inside RUN that must be ignored.
    mode = 1;
    applyStimulus(1'b1);
    aligned = 1'b0;
    repeat (50) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (DONE_E - 51 + 3) applyStimulus(1'b0);
    checkValue("toggle_count_at_done", {16'd0, oChangeCount}, 32'd100);

    // Same pattern twice, then once with a single flipped bit.
    mode = 2;
    applyStimulus(1'b1);
    repeat (DONE_E + 1) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (DONE_E + 1) applyStimulus(1'b0);
    mode = 3;
    applyStimulus(1'b1);
    repeat (DONE_E + 1) applyStimulus(1'b0);

    // Asynchronous reset at RUN cycle 50.
    mode = 1;
    applyStimulus(1'b1);
    repeat (RUN_START + 50) applyStimulus(1'b0);
    #2 Reset = 1'b1;
    #1 checkReset("async_reset");
    q.delete();
    resetModel();
    @(posedge Clock);
    #1 checkReset("reset_held");
    #2 Reset = 1'b0;
    aligned = 1'b1;
    mode = 0;
    repeat (DONE_E + 1) applyStimulus(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
